// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor: pulses the PLL reset, waits for a
// stable synchronized lock, releases the system reset, and re-arms on lock loss.
module pll_reset_ctrl #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 4,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic             fail,
    output logic             lock_lost,
    output logic [CNT_W-1:0] relock_count
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);
    localparam int RTY_W   = $clog2(MAX_RETRIES + 1);

    localparam logic [CYC_W-1:0] PLL_RST_LAST = CYC_W'(PLL_RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);
    localparam logic [CYC_W-1:0] STABLE_LAST  = CYC_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RETRY_LIMIT  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [CYC_W-1:0]   cyc_reg, cyc_next;
    logic [RTY_W-1:0]   retry_reg, retry_next;
    logic [CNT_W-1:0]   relock_reg, relock_next;
    logic [1:0]         sync_reg;
    logic               locked_s;
    logic               pll_rst_reg, pll_rst_next;
    logic               sys_rst_reg, sys_rst_next;
    logic               ready_reg, ready_next;
    logic               fail_reg, fail_next;
    logic               lock_lost_reg, lock_lost_next;

    // locked is asynchronous to refclk; only the second flop is used.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], locked};
        end
    end

    assign locked_s = sync_reg[1];

    always_comb begin
        state_next     = state_reg;
        cyc_next       = cyc_reg;
        retry_next     = retry_reg;
        relock_next    = relock_reg;
        lock_lost_next = 1'b0;

        case (state_reg)
            PLL_RESET: begin
                if (cyc_reg == PLL_RST_LAST) begin
                    state_next = WAIT_LOCK;
                    cyc_next   = '0;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = STABLE;
                    cyc_next   = '0;
                end else if (cyc_reg == TIMEOUT_LAST) begin
                    cyc_next   = '0;
                    retry_next = retry_reg + RTY_W'(1);
                    state_next = (retry_next == RETRY_LIMIT) ? FAIL : PLL_RESET;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            STABLE: begin
                // A dropout here restarts the lock wait but is not a failed attempt.
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                    cyc_next   = '0;
                end else if (cyc_reg == STABLE_LAST) begin
                    state_next = RUN;
                    cyc_next   = '0;
                    retry_next = '0;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_next     = PLL_RESET;
                    cyc_next       = '0;
                    lock_lost_next = 1'b1;
                    if (relock_reg != '1) begin
                        relock_next = relock_reg + CNT_W'(1);
                    end
                end
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: begin
                state_next = PLL_RESET;
                cyc_next   = '0;
            end
        endcase

        // Outputs follow the state being entered so they change on the same edge.
        pll_rst_next = (state_next == PLL_RESET) || (state_next == FAIL);
        sys_rst_next = (state_next != RUN);
        ready_next   = (state_next == RUN);
        fail_next    = (state_next == FAIL);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_reg     <= PLL_RESET;
            cyc_reg       <= '0;
            retry_reg     <= '0;
            relock_reg    <= '0;
            pll_rst_reg   <= 1'b1;
            sys_rst_reg   <= 1'b1;
            ready_reg     <= 1'b0;
            fail_reg      <= 1'b0;
            lock_lost_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            retry_reg     <= retry_next;
            relock_reg    <= relock_next;
            pll_rst_reg   <= pll_rst_next;
            sys_rst_reg   <= sys_rst_next;
            ready_reg     <= ready_next;
            fail_reg      <= fail_next;
            lock_lost_reg <= lock_lost_next;
        end
    end

    assign pll_rst      = pll_rst_reg;
    assign sys_rst      = sys_rst_reg;
    assign ready        = ready_reg;
    assign fail         = fail_reg;
    assign lock_lost    = lock_lost_reg;
    assign relock_count = relock_reg;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short simulation parameters; each
// step lands on an exact edge number computed by hand from the sequencing rules.
module tb_pll_reset_ctrl;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic       lock_lost;
    logic [1:0] relock_count;

    int checks = 0;
    int errors = 0;
    int t      = 0;
    int b      = 0;

    pll_reset_ctrl #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .CNT_W         (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .locked      (locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .fail        (fail),
        .lock_lost   (lock_lost),
        .relock_count(relock_count)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Advance to just after posedge number e (edges counted from time zero).
    task automatic at(input int e);
        while (t < e) begin
            @(posedge refclk);
            #1;
            t++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, t);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".pll_rst"},      pll_rst, 1);
        chk({tag, ".sys_rst"},      sys_rst, 1);
        chk({tag, ".ready"},        ready, 0);
        chk({tag, ".fail"},         fail, 0);
        chk({tag, ".lock_lost"},    lock_lost, 0);
        chk({tag, ".relock_count"}, relock_count, 0);
    endtask

    initial begin
        rst    = 1'b1;
        locked = 1'b0;

        at(3);
        chk_reset_vals("reset");
        $display("step reset: outputs at reset values, edge %0d", t);

        // Nominal bring-up, lock rising late
        rst = 1'b0;
        b   = t;
        at(b + 3);  chk("nom.pll_rst_held", pll_rst, 1);
        at(b + 4);  chk("nom.pll_rst_fall", pll_rst, 0);
                    chk("nom.sys_rst_wait", sys_rst, 1);
        at(b + 9);  locked = 1'b1;
        at(b + 19); chk("nom.sys_rst_pre", sys_rst, 1);
                    chk("nom.ready_pre", ready, 0);
        at(b + 20); chk("nom.sys_rst_rel", sys_rst, 0);
                    chk("nom.ready", ready, 1);
                    chk("nom.fail", fail, 0);
                    chk("nom.pll_rst", pll_rst, 0);
        $display("step nominal: released at edge %0d", t);

        // First lock loss in RUN, 5 cycles low
        b = t;
        locked = 1'b0;
        at(b + 2);  chk("loss1.lock_lost_early", lock_lost, 0);
                    chk("loss1.ready_early", ready, 1);
        at(b + 3);  chk("loss1.lock_lost", lock_lost, 1);
                    chk("loss1.relock_count", relock_count, 1);
                    chk("loss1.sys_rst", sys_rst, 1);
                    chk("loss1.pll_rst", pll_rst, 1);
                    chk("loss1.ready", ready, 0);
        at(b + 4);  chk("loss1.lock_lost_once", lock_lost, 0);
        at(b + 5);  locked = 1'b1;
        at(b + 15); chk("loss1.ready_pre", ready, 0);
        at(b + 16); chk("loss1.ready_again", ready, 1);
                    chk("loss1.sys_rst_rel", sys_rst, 0);
        $display("step loss1: relock_count=%0d, ready again at edge %0d", relock_count, t);

        // Second loss: two timeouts, then instability at stable count 5
        b = t;
        locked = 1'b0;
        at(b + 3);  chk("loss2.lock_lost", lock_lost, 1);
                    chk("loss2.relock_count", relock_count, 2);
        at(b + 6);  chk("loss2.pll_rst_held", pll_rst, 1);
        at(b + 7);  chk("loss2.pll_rst_fall", pll_rst, 0);
        at(b + 26); chk("loss2.wait_low", pll_rst, 0);
        at(b + 27); chk("loss2.timeout1_pll", pll_rst, 1);
                    chk("loss2.timeout1_fail", fail, 0);
        at(b + 51); chk("loss2.timeout2_pll", pll_rst, 1);
                    chk("loss2.timeout2_fail", fail, 0);
        at(b + 53); locked = 1'b1;
        at(b + 59); locked = 1'b0;
        at(b + 61); locked = 1'b1;
        at(b + 63); chk("unstable.sys_rst", sys_rst, 1);
                    chk("unstable.pll_rst", pll_rst, 0);
        at(b + 64); chk("unstable.no_early_run", ready, 0);
                    chk("unstable.sys_rst_hold", sys_rst, 1);
        at(b + 71); chk("unstable.ready_pre", ready, 0);
        at(b + 72); chk("unstable.ready", ready, 1);
                    chk("unstable.fail", fail, 0);
        $display("step loss2+instability: ready at edge %0d", t);

        // Third loss: two more timeouts must not reach the retry limit
        b = t;
        locked = 1'b0;
        at(b + 3);  chk("loss3.relock_count", relock_count, 3);
                    chk("loss3.lock_lost", lock_lost, 1);
        at(b + 27); chk("loss3.timeout1_pll", pll_rst, 1);
                    chk("loss3.timeout1_fail", fail, 0);
        at(b + 51); chk("loss3.timeout2_pll", pll_rst, 1);
                    chk("loss3.timeout2_fail", fail, 0);
        at(b + 53); locked = 1'b1;
        at(b + 63); chk("loss3.ready_pre", ready, 0);
        at(b + 64); chk("loss3.ready", ready, 1);
                    chk("loss3.fail", fail, 0);
        $display("step loss3: retries cleared, ready at edge %0d", t);

        // Losses 4 and 5: relock_count saturates at 3
        b = t;
        locked = 1'b0;
        at(b + 3);  chk("loss4.relock_sat", relock_count, 3);
                    chk("loss4.lock_lost", lock_lost, 1);
        at(b + 5);  locked = 1'b1;
        at(b + 16); chk("loss4.ready", ready, 1);
        b = t;
        locked = 1'b0;
        at(b + 3);  chk("loss5.relock_sat", relock_count, 3);
                    chk("loss5.lock_lost", lock_lost, 1);
        at(b + 5);  locked = 1'b1;
        $display("step saturation: relock_count=%0d", relock_count);

        // Reset while in STABLE (stable count 3)
        at(b + 11); chk("midstable.sys_rst", sys_rst, 1);
                    chk("midstable.pll_rst", pll_rst, 0);
        rst = 1'b1;
        at(b + 12); chk_reset_vals("midstable_rst");
        rst = 1'b0;
        b = t;
        at(b + 12); chk("minrel.sys_rst_pre", sys_rst, 1);
        at(b + 13); chk("minrel.sys_rst", sys_rst, 0);
                    chk("minrel.ready", ready, 1);
                    chk("minrel.relock_count", relock_count, 0);
        $display("step reset mid-STABLE: minimum release at edge %0d", t);

        // Reset while in RUN, then lock never arrives
        rst = 1'b1;
        locked = 1'b0;
        at(t + 1);  chk("midrun.sys_rst", sys_rst, 1);
                    chk("midrun.ready", ready, 0);
                    chk("midrun.pll_rst", pll_rst, 1);
                    chk("midrun.lock_lost", lock_lost, 0);
        at(t + 1);
        rst = 1'b0;
        b = t;
        at(b + 3);  chk("to.p1_high", pll_rst, 1);
        at(b + 4);  chk("to.p1_fall", pll_rst, 0);
        at(b + 23); chk("to.w1_low", pll_rst, 0);
        at(b + 24); chk("to.p2_rise", pll_rst, 1);
                    chk("to.p2_fail", fail, 0);
        at(b + 27); chk("to.p2_high", pll_rst, 1);
        at(b + 28); chk("to.p2_fall", pll_rst, 0);
        at(b + 47); chk("to.w2_low", pll_rst, 0);
        at(b + 48); chk("to.p3_rise", pll_rst, 1);
        at(b + 52); chk("to.p3_fall", pll_rst, 0);
        at(b + 71); chk("to.w3_low", pll_rst, 0);
                    chk("to.w3_fail", fail, 0);
        at(b + 72); chk("to.fail", fail, 1);
                    chk("to.fail_pll_rst", pll_rst, 1);
                    chk("to.fail_sys_rst", sys_rst, 1);
        locked = 1'b1;
        at(b + 100); chk("to.fail_sticky", fail, 1);
                     chk("to.fail_ready", ready, 0);
                     chk("to.fail_pll_hold", pll_rst, 1);
        $display("step timeout: fail raised at edge %0d", b + 72);

        rst = 1'b1;
        at(t + 1);  chk("clear.fail", fail, 0);
                    chk("clear.pll_rst", pll_rst, 1);
        rst = 1'b0;
        $display("step fail clear: rst pulse at edge %0d", t);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
